// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction format,
// opcode constants, the idle word and the sequencer state encoding.
package inst_sequencer_pkg;

   localparam int INST_BITS = 16;
   localparam int OPCODE_HI = 15;
   localparam int OPCODE_LO = 12;

   localparam logic [3:0] OP_NOP         = 4'h0;
   localparam logic [3:0] OP_LOAD_WEIGHT = 4'h1;
   localparam logic [3:0] OP_LOAD_DATA   = 4'h2;
   localparam logic [3:0] OP_MAT_MUL     = 4'h3;
   localparam logic [3:0] OP_STORE       = 4'h4;

   // The control unit treats a NOP with zero operand as "do nothing".
   localparam logic [INST_BITS-1:0] IDLE_INST = {OP_NOP, 12'h000};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } seq_state_e;

   function automatic logic [INST_BITS-1:0] make_inst(input logic [3:0] op,
                                                      input logic [11:0] arg);
      logic [INST_BITS-1:0] inst;
      inst = '0;
      inst[OPCODE_HI:OPCODE_LO] = op;
      inst[OPCODE_LO-1:0] = arg;
      return inst;
   endfunction

endpackage

// File: rtl/inst_sequencer_fifo.sv
// Synchronous show-ahead FIFO: head always shows the oldest entry, a pop
// simply advances past it. Flush empties the FIFO and beats push/pop.
module inst_sequencer_fifo #(
   parameter int DEPTH    = 16,
   parameter int WIDTH    = 16,
   parameter int PTR_BITS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                push,
   input  logic                pop,
   input  logic [WIDTH-1:0]    wdata,
   output logic [WIDTH-1:0]    head,
   output logic                full,
   output logic                empty,
   output logic [PTR_BITS:0]   count
);

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == (PTR_BITS+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointers are exactly PTR_BITS wide, so wrap is the natural overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/inst_sequencer.sv
// Host instruction queue and program sequencer: hands one queued instruction
// to the control unit per cu_flag, counts them against prog_len, pulses done.
module inst_sequencer
   import inst_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int PTR_BITS   = 4,
   parameter int CNT_BITS   = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [INST_BITS-1:0] in_inst,
   output logic                 in_ready,
   input  logic [CNT_BITS-1:0]  prog_len,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 cu_flag,
   output logic [INST_BITS-1:0] instruction,
   output logic                 busy,
   output logic                 done,
   output logic [PTR_BITS:0]    fifo_count,
   output logic [CNT_BITS-1:0]  issued_cnt,
   output logic [1:0]           dbg_state
);

   // Handshake: a word moves host->FIFO on a clock edge where in_valid and
   // in_ready are both high; in_ready depends only on registered occupancy.

   seq_state_e           state_q;
   seq_state_e           state_d;
   logic [CNT_BITS-1:0]  len_q;
   logic [INST_BITS-1:0] fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 can_issue;
   logic                 pop;
   logic                 push;

   inst_sequencer_fifo #(
      .DEPTH    (FIFO_DEPTH),
      .WIDTH    (INST_BITS),
      .PTR_BITS (PTR_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (abort),
      .push    (push),
      .pop     (pop),
      .wdata   (in_inst),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign in_ready  = ~fifo_full;
   assign push      = in_valid & in_ready;
   // Built from registers only, so the word shown is exactly what the CU latches.
   assign can_issue = (state_q == S_RUN) & ~fifo_empty & (issued_cnt < len_q);
   assign pop       = can_issue & cu_flag & ~abort;

   assign instruction = can_issue ? fifo_head : IDLE_INST;
   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign dbg_state   = state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         // Completion needs one more cu_flag after the last pop so the final
         // multi-cycle instruction has actually finished in the CU.
         S_RUN:   if (cu_flag && (issued_cnt == len_q)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q      <= '0;
         issued_cnt <= '0;
      end else if (!abort) begin
         if ((state_q == S_IDLE) && start) begin
            len_q      <= prog_len;
            issued_cnt <= '0;
         end else if (pop) begin
            issued_cnt <= issued_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: a small CU model consumes issued words
// and a scoreboard queue holds the words expected in issue order.
module tb_inst_sequencer;
   import inst_sequencer_pkg::*;

   localparam int DEPTH    = 16;
   localparam int PTR_BITS = 4;
   localparam int CNT_BITS = 16;

   logic                 clk;
   logic                 reset_n;
   logic                 in_valid;
   logic [INST_BITS-1:0] in_inst;
   logic                 in_ready;
   logic [CNT_BITS-1:0]  prog_len;
   logic                 start;
   logic                 abort;
   logic                 cu_flag;
   logic [INST_BITS-1:0] instruction;
   logic                 busy;
   logic                 done;
   logic [PTR_BITS:0]    fifo_count;
   logic [CNT_BITS-1:0]  issued_cnt;
   logic [1:0]           dbg_state;

   int n_vec;
   int n_err;
   int cap_cnt;
   int cu_wait;
   logic [INST_BITS-1:0] exp_q[$];

   inst_sequencer #(
      .FIFO_DEPTH (DEPTH),
      .PTR_BITS   (PTR_BITS),
      .CNT_BITS   (CNT_BITS)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_inst     (in_inst),
      .in_ready    (in_ready),
      .prog_len    (prog_len),
      .start       (start),
      .abort       (abort),
      .cu_flag     (cu_flag),
      .instruction (instruction),
      .busy        (busy),
      .done        (done),
      .fifo_count  (fifo_count),
      .issued_cnt  (issued_cnt),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_word(input logic [INST_BITS-1:0] w);
      in_valid = 1'b1;
      in_inst  = w;
      tick();
      in_valid = 1'b0;
      exp_q.push_back(w);
   endtask

   // CU capture: at a negedge where cu_flag is being raised, the word shown
   // is the word the CU loads at the coming edge.
   task automatic cu_capture(input string tag);
      cap_cnt++;
      if (exp_q.size() > 0) chk(tag, 32'(instruction), 32'(exp_q.pop_front()));
      else                  chk({tag, "_unexpected"}, 32'(instruction), 32'(IDLE_INST));
   endtask

   task automatic start_run(input logic [CNT_BITS-1:0] len);
      prog_len = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // CU model: each loaded instruction keeps the CU busy for two more cycles.
   task automatic run_until_done(input int max_cycles, output bit got_done);
      got_done = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (cu_wait == 0) begin
            cu_flag = 1'b1;
            if (instruction !== IDLE_INST) begin
               cu_capture("issue");
               cu_wait = 2;
            end
         end else begin
            cu_flag = 1'b0;
            cu_wait--;
         end
         tick();
      end
      cu_flag = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"},   32'(in_ready),    32'd1);
      chk({tag, "_busy"},       32'(busy),        32'd0);
      chk({tag, "_done"},       32'(done),        32'd0);
      chk({tag, "_count"},      32'(fifo_count),  32'd0);
      chk({tag, "_issued"},     32'(issued_cnt),  32'd0);
      chk({tag, "_inst"},       32'(instruction), 32'(IDLE_INST));
      chk({tag, "_state"},      32'(dbg_state),   32'(S_IDLE));
   endtask

   // ---------------- scenarios ----------------
   initial begin
      bit got_done;
      logic [INST_BITS-1:0] w;
      n_vec = 0; n_err = 0; cap_cnt = 0; cu_wait = 0;
      reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; prog_len = '0;
      start = 1'b0; abort = 1'b0; cu_flag = 1'b0;
      tick(); tick();
      check_reset_values("reset");
      reset_n = 1'b1;
      tick();

      // 1: preload three words, run them out in order
      push_word(make_inst(OP_LOAD_WEIGHT, 12'h011));
      push_word(make_inst(OP_LOAD_DATA,   12'h022));
      push_word(make_inst(OP_MAT_MUL,     12'h033));
      chk("t1_preload_count", 32'(fifo_count), 32'd3);
      start_run(16'd3);
      chk("t1_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_no_pop_without_flag", 32'(fifo_count), 32'd3);
      chk("t1_head_shown", 32'(instruction), 32'(make_inst(OP_LOAD_WEIGHT, 12'h011)));
      cap_cnt = 0; cu_wait = 0;
      run_until_done(60, got_done);
      chk("t1_done_seen", 32'(got_done), 32'd1);
      chk("t1_captures", 32'(cap_cnt), 32'd3);
      chk("t1_issued", 32'(issued_cnt), 32'd3);
      chk("t1_count_empty", 32'(fifo_count), 32'd0);
      tick();
      chk("t1_done_one_cycle", 32'(done), 32'd0);
      chk("t1_idle", 32'(dbg_state), 32'(S_IDLE));

      // 2: fill to full, rejected push, pop+push at full and when not full
      for (int i = 0; i < DEPTH; i++) push_word(make_inst(OP_STORE, 12'(i)));
      chk("t2_full_count", 32'(fifo_count), 32'd16);
      chk("t2_full_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_inst  = make_inst(OP_MAT_MUL, 12'hBAD);
      tick();
      chk("t2_reject_count", 32'(fifo_count), 32'd16);
      start_run(16'd1);
      chk("t2_run_busy", 32'(busy), 32'd1);
      cu_flag = 1'b1;
      cu_capture("t2_issue_full");
      tick();
      cu_flag = 1'b0; in_valid = 1'b0;
      chk("t2_pop_push_full_count", 32'(fifo_count), 32'd15);
      chk("t2_ready_again", 32'(in_ready), 32'd1);
      cu_flag = 1'b1;
      tick();
      cu_flag = 1'b0;
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_issued", 32'(issued_cnt), 32'd1);
      tick();
      start_run(16'd1);
      w = make_inst(OP_LOAD_DATA, 12'h5A5);
      cu_flag = 1'b1; in_valid = 1'b1; in_inst = w;
      cu_capture("t2_issue_nonfull");
      tick();
      exp_q.push_back(w);
      in_valid = 1'b0;
      chk("t2_pop_push_count", 32'(fifo_count), 32'd15);
      tick();
      cu_flag = 1'b0;
      chk("t2_done2", 32'(done), 32'd1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      chk("t2_flush_idle", 32'(fifo_count), 32'd0);

      // 3: stall on empty FIFO mid-run, then resume
      push_word(make_inst(OP_LOAD_WEIGHT, 12'h101));
      push_word(make_inst(OP_LOAD_DATA,   12'h102));
      start_run(16'd4);
      cap_cnt = 0; cu_wait = 0;
      run_until_done(16, got_done);
      chk("t3_stall_no_done", 32'(got_done), 32'd0);
      chk("t3_stall_inst", 32'(instruction), 32'(IDLE_INST));
      chk("t3_stall_busy", 32'(busy), 32'd1);
      chk("t3_stall_issued", 32'(issued_cnt), 32'd2);
      push_word(make_inst(OP_MAT_MUL, 12'h103));
      push_word(make_inst(OP_STORE,   12'h104));
      cu_wait = 0;
      run_until_done(60, got_done);
      chk("t3_done_seen", 32'(got_done), 32'd1);
      chk("t3_captures", 32'(cap_cnt), 32'd4);
      chk("t3_issued", 32'(issued_cnt), 32'd4);
      tick();

      // 4: zero-length program leaves the queue alone
      push_word(make_inst(OP_LOAD_WEIGHT, 12'h201));
      push_word(make_inst(OP_LOAD_DATA,   12'h202));
      cu_flag = 1'b1;
      start_run(16'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_inst_idle", 32'(instruction), 32'(IDLE_INST));
      tick();
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_issued", 32'(issued_cnt), 32'd0);
      chk("t4_count", 32'(fifo_count), 32'd2);
      cu_flag = 1'b0;
      tick();
      chk("t4_done_drop", 32'(done), 32'd0);

      // 5: abort mid-run with five queued, then start+abort together
      for (int i = 0; i < 4; i++) push_word(make_inst(OP_MAT_MUL, 12'(12'h300 + i)));
      start_run(16'd8);
      cu_flag = 1'b1;
      cu_capture("t5_issue");
      tick();
      cu_flag = 1'b0;
      chk("t5_queued", 32'(fifo_count), 32'd5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      chk("t5_abort_busy", 32'(busy), 32'd0);
      chk("t5_abort_state", 32'(dbg_state), 32'(S_IDLE));
      chk("t5_abort_count", 32'(fifo_count), 32'd0);
      chk("t5_abort_done", 32'(done), 32'd0);
      chk("t5_abort_issued_held", 32'(issued_cnt), 32'd1);
      tick();
      chk("t5_no_late_done", 32'(done), 32'd0);
      push_word(make_inst(OP_STORE, 12'h399));
      exp_q.delete();
      start = 1'b1; abort = 1'b1; prog_len = 16'd1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("t5_sa_busy", 32'(busy), 32'd0);
      chk("t5_sa_state", 32'(dbg_state), 32'(S_IDLE));
      chk("t5_sa_count", 32'(fifo_count), 32'd0);

      // 6: asynchronous reset mid-run, then a clean run
      push_word(make_inst(OP_LOAD_WEIGHT, 12'h401));
      push_word(make_inst(OP_LOAD_DATA,   12'h402));
      push_word(make_inst(OP_MAT_MUL,     12'h403));
      start_run(16'd3);
      cu_flag = 1'b1;
      cu_capture("t6_issue");
      tick();
      cu_flag = 1'b0;
      chk("t6_pre_reset_issued", 32'(issued_cnt), 32'd1);
      #2 reset_n = 1'b0;
      #1 check_reset_values("t6_async");
      #1 reset_n = 1'b1;
      tick();
      exp_q.delete();
      push_word(make_inst(OP_LOAD_DATA, 12'h501));
      push_word(make_inst(OP_MAT_MUL,   12'h502));
      push_word(make_inst(OP_STORE,     12'h503));
      start_run(16'd3);
      cap_cnt = 0; cu_wait = 0;
      run_until_done(60, got_done);
      chk("t6_done_seen", 32'(got_done), 32'd1);
      chk("t6_captures", 32'(cap_cnt), 32'd3);
      chk("t6_issued", 32'(issued_cnt), 32'd3);
      tick();

      // ---------------- report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
